// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing controller: opcode constants,
// FSM state encoding and the round-robin pointer helper.
package alu_pkg;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5;
  localparam logic [4:0] OP_NOR = 5'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } share_state_t;

  // Priority pointer after granting idx: the next requester, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req from ptr upward with
// wrap-around and returns a one-hot grant plus its binary index.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;
  int   j;

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin time-multiplexing of one external combinational ALU among
// N_REQ requesters. Optional statistics counters: define ALU_SHARE_STATS_EN.
module alu_share_ctrl #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [OP_W-1:0]         alu_op,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_out,
  output logic                    busy
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [31:0]             op_count,
  output logic [31:0]             stall_cycles
`endif
);

  import alu_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);

  share_state_t      state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  gidx_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [N_REQ-1:0]  rsp_valid_q;

  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              rsp_hs;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  // Gated by rst_n so that every output reads 0 while reset is asserted.
  assign req_ready = (rst_n && state_q == IDLE) ? grant : '0;
  assign rsp_hs    = (state_q == RESP) && rsp_ready[gidx_q];

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register sits in the async reset branch (there are no memories here).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            gidx_q   <= grant_idx;
            alu_op_q <= req_op[grant_idx*OP_W +: OP_W];
            alu_a_q  <= req_a[grant_idx*DATA_W +: DATA_W];
            alu_b_q  <= req_b[grant_idx*DATA_W +: DATA_W];
            ptr_q    <= IDX_W'(rr_next(int'(grant_idx), N_REQ));
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_out;
          rsp_valid_q <= N_REQ'(1) << gidx_q;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid_q <= '0;
            alu_op_q    <= OP_W'(OP_NOP);
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign busy      = (state_q != IDLE);

`ifdef ALU_SHARE_STATS_EN
  // 0: counters wrap modulo 2^32, 1: counters stick at all-ones.
  localparam bit ALU_SAT = 1'b0;

  logic [31:0] op_count_q;
  logic [31:0] stall_q;
  logic        stall_now;

  assign stall_now = |(req_valid & ~req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
      stall_q    <= '0;
    end else begin
      if (rsp_hs && !(ALU_SAT && op_count_q == '1)) op_count_q <= op_count_q + 32'd1;
      if (stall_now && !(ALU_SAT && stall_q == '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign op_count     = op_count_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: table-driven single ops plus
// sequences for round-robin order, response backpressure and mid-op reset.
module tb_alu_share_ctrl;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*OP_W-1:0]   req_op = '0;
  logic [N_REQ*DATA_W-1:0] req_a = '0;
  logic [N_REQ*DATA_W-1:0] req_b = '0;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready = '0;
  logic [DATA_W-1:0]       rsp_data;
  logic [OP_W-1:0]         alu_op;
  logic [DATA_W-1:0]       alu_a;
  logic [DATA_W-1:0]       alu_b;
  logic [DATA_W-1:0]       alu_out;
  logic                    busy;
`ifdef ALU_SHARE_STATS_EN
  logic [31:0]             op_count;
  logic [31:0]             stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.N_REQ(N_REQ), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .busy      (busy)
`ifdef ALU_SHARE_STATS_EN
    ,
    .op_count     (op_count),
    .stall_cycles (stall_cycles)
`endif
  );

  // The shared ALU that sits beside the controller.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      5'd1: alu_out = alu_a + alu_b;
      5'd2: alu_out = alu_a - alu_b;
      5'd3: alu_out = alu_a & alu_b;
      5'd4: alu_out = alu_a | alu_b;
      5'd5: alu_out = alu_a ^ alu_b;
      5'd6: alu_out = ~(alu_a | alu_b);
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    int          r;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_req(input int r, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[r*OP_W +: OP_W]     = op;
    req_a[r*DATA_W +: DATA_W]  = a;
    req_b[r*DATA_W +: DATA_W]  = b;
  endtask

  // One isolated operation from requester r, checked at every phase.
  task automatic do_op(input string tag, input int r, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [3:0] onehot;
    onehot = 4'(1 << r);
    set_req(r, op, a, b);
    req_valid = onehot;
    #1;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'(onehot));
    step();
    req_valid = '0;
    check({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_exec_rspv"}, 32'(rsp_valid), 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'(op));
    check({tag, "_alu_a"}, alu_a, a);
    check({tag, "_alu_b"}, alu_b, b);
    step();
    check({tag, "_rspv"}, 32'(rsp_valid), 32'(onehot));
    check({tag, "_rsp_data"}, rsp_data, exp);
    rsp_ready = onehot;
    step();
    rsp_ready = '0;
    check({tag, "_done_rspv"}, 32'(rsp_valid), 32'd0);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_nop"}, 32'(alu_op), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] got[5];
    int         at[5];
    int         n;
    logic [31:0] held;

    vecs[0] = '{2, 5'd1, 32'd5,          32'hFFFF_FFFD, 32'd2};
    vecs[1] = '{0, 5'd2, 32'd10,         32'd20,        32'hFFFF_FFF6};
    vecs[2] = '{1, 5'd3, 32'hF0F0_F0F0,  32'hFF00_FF00, 32'hF000_F000};
    vecs[3] = '{3, 5'd4, 32'h0000_00FF,  32'h0000_FF00, 32'h0000_FFFF};
    vecs[4] = '{2, 5'd5, 32'hFFFF_0000,  32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vecs[5] = '{0, 5'd6, 32'h0,          32'h0,         32'hFFFF_FFFF};
    vecs[6] = '{1, 5'd7, 32'd1,          32'd2,         32'h0};
    vecs[7] = '{3, 5'd2, 32'h8000_0000,  32'd1,         32'h7FFF_FFFF};

    // Reset state
    do_reset();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rspv", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);

    // Single ops and passthrough/width cases
    for (int i = 0; i < 8; i++)
      do_op($sformatf("v%0d", i), vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Response backpressure: ptr lands at 1, grant 1, then 0 and 3 contend
    do_reset();
    do_op("bp_pre", 0, 5'd1, 32'd1, 32'd1, 32'd2);
    set_req(1, 5'd1, 32'd7, 32'd8);
    req_valid = 4'b0010;
    #1;
    check("bp_grant1", 32'(req_ready), 32'b0010);
    step();
    set_req(0, 5'd2, 32'd9, 32'd4);
    set_req(3, 5'd4, 32'h0000_0F00, 32'h0000_00F0);
    req_valid = 4'b1001;
    #1;
    check("bp_exec_ready", 32'(req_ready), 32'd0);
    step();
    check("bp_rspv", 32'(rsp_valid), 32'b0010);
    check("bp_data", rsp_data, 32'd15);
    held = rsp_data;
    rsp_ready = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp_hold_rspv%0d", c), 32'(rsp_valid), 32'b0010);
      check($sformatf("bp_hold_data%0d", c), rsp_data, held);
      check($sformatf("bp_hold_ready%0d", c), 32'(req_ready), 32'd0);
    end
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    check("bp_next_grant3", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    check("bp_g3_alu_a", alu_a, 32'h0000_0F00);
    step();
    check("bp_g3_data", rsp_data, 32'h0000_0FF0);
    rsp_ready = 4'b1000;
    step();
    rsp_ready = '0;

    // Reset in the middle of EXEC
    set_req(3, 5'd1, 32'd1, 32'd1);
    req_valid = 4'b1000;
    #1;
    check("rm_grant", 32'(req_ready), 32'b1000);
    step();
    check("rm_exec_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_ready", 32'(req_ready), 32'd0);
    check("rm_alu_op", 32'(alu_op), 32'd0);
    check("rm_alu_a", alu_a, 32'd0);
    check("rm_alu_b", alu_b, 32'd0);
    check("rm_rspv", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rm_regrant3", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    check("rm_alu_a_after", alu_a, 32'd1);
    step();
    check("rm_rsp_data", rsp_data, 32'd2);
    rsp_ready = 4'b1000;
    step();
    rsp_ready = '0;

    // Leave ptr at 2 so the reset below must restore requester-0 priority
    do_op("pre_rr", 1, 5'd1, 32'd3, 32'd4, 32'd7);

    // Round-robin under continuous all-valid SUB requests
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 5'd2, 32'(10 * (i + 1)), 32'(i));
    for (int k = 0; k < 5; k++) begin
      got[k] = '0;
      at[k]  = 0;
    end
    n = 0;
    rsp_ready = '1;
    req_valid = '1;
    #1;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (req_ready != '0) begin
        got[n] = req_ready;
        at[n]  = c;
        n++;
      end
      step();
    end
    check("rr_grant_count", 32'(n), 32'd5);
    for (int k = 0; k < 5; k++)
      check($sformatf("rr_grant%0d", k), 32'(got[k]), 32'(1 << (k % N_REQ)));
    for (int k = 1; k < 5; k++)
      check($sformatf("rr_spacing%0d", k), 32'(at[k] - at[k-1]), 32'd3);
    req_valid = '0;
    step();
    step();
    step();
    rsp_ready = '0;
    check("rr_drained", 32'(busy), 32'd0);

`ifdef ALU_SHARE_STATS_EN
    // Two contenders, always ready: every cycle has an unaccepted request
    do_reset();
    set_req(0, 5'd1, 32'd1, 32'd2);
    set_req(2, 5'd1, 32'd3, 32'd4);
    rsp_ready = '1;
    req_valid = 4'b0101;
    for (int c = 0; c < 30; c++) step();
    req_valid = '0;
    rsp_ready = '0;
    check("st_op_count", op_count, 32'd10);
    check("st_stall", stall_cycles, 32'd30);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
